// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: memory op
// encodings, completion status codes, FSM states and decode helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        MEMOP_LB  = 3'd0,
        MEMOP_LBU = 3'd1,
        MEMOP_LH  = 3'd2,
        MEMOP_LHU = 3'd3,
        MEMOP_LW  = 3'd4,
        MEMOP_SB  = 3'd5,
        MEMOP_SH  = 3'd6,
        MEMOP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Store ops occupy the upper encodings SB..SW.
    function automatic logic is_store(input logic [2:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic w_half;
        logic w_word;
        w_half = (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
        w_word = (op == MEMOP_LW) || (op == MEMOP_SW);
        return (w_half && addr_lo[0]) || (w_word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/halfword lane out of a memory
// word and sign- or zero-extends it. Purely combinational so the
// single-cycle datapath's writeback path can share it.
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_mem_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_dm_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes (little-endian).
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned and infers a latch.
        w_byte = i_dm_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_dm_rdata[15:8];
            2'd2:    w_byte = i_dm_rdata[23:16];
            2'd3:    w_byte = i_dm_rdata[31:24];
            default: w_byte = i_dm_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
    end

    // Extend the selected lane according to the load type; words pass through.
    always_comb begin
        o_rdata = i_dm_rdata;
        case (i_mem_op)
            MEMOP_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            MEMOP_LBU: o_rdata = {24'd0, w_byte};
            MEMOP_LH:  o_rdata = {{16{w_half[15]}}, w_half};
            MEMOP_LHU: o_rdata = {16'd0, w_half};
            default:   o_rdata = i_dm_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Latches one request from the EX stage,
// rejects misaligned accesses, runs a req/ack transfer to data memory with
// a wait-state timeout, and returns aligned load data plus a done pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT          = 16,
    parameter bit ZERO_STORE_RDATA = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    state_e      r_state;
    state_e      w_next_state;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [3:0]  r_dm_be;
    logic [31:0] r_dm_wdata;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_misaligned;
    logic        w_limit;

    assign w_misaligned = is_misaligned(mem_op, addr[1:0]);
    assign w_limit      = (r_cnt == 8'(TIMEOUT - 1));

    // Store byte enables and lane-replicated data from the incoming request.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_in;
        case (mem_op)
            MEMOP_SB: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata_in[7:0]}};
            end
            MEMOP_SH: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_in[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_in;
            end
        endcase
    end

    load_align u_load_align (
        .i_mem_op   (r_op),
        .i_addr_lo  (r_addr_lo),
        .i_dm_rdata (dm_rdata),
        .o_rdata    (w_load_data)
    );

    // State register; reset drops dm_req immediately and abandons the access.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, whatever the block order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        dm_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = w_misaligned ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                busy   = 1'b1;
                dm_req = 1'b1;
                if (dm_ack || w_limit) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latching, wait counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset as well, since rdata/err/dm_* are observable outputs whose reset value is defined as zero.
        if (rst) begin
            r_op       <= '0;
            r_addr_lo  <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= '0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_be    <= '0;
            r_dm_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_op       <= mem_op;
                        r_addr_lo  <= addr[1:0];
                        r_dm_addr  <= {addr[31:2], 2'b00};
                        r_dm_be    <= w_be;
                        r_dm_wdata <= w_wdata;
                        r_dm_we    <= is_store(mem_op);
                        if (w_misaligned) begin
                            r_rdata <= '0;
                            r_err   <= ERR_ALIGN;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over the timeout limit in the same cycle.
                    if (dm_ack) begin
                        r_rdata <= (ZERO_STORE_RDATA && is_store(r_op)) ? 32'd0 : w_load_data;
                        r_err   <= ERR_OK;
                    end else if (w_limit) begin
                        r_rdata <= '0;
                        r_err   <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign err      = r_err;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_be    = r_dm_be;
    assign dm_wdata = r_dm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses, each compared against a behavioural model of the lane, error
// and latency rules.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;
    localparam int LIMIT   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .ZERO_STORE_RDATA(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata_in (wdata_in),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_is_store(input int op);
        return op >= 5;
    endfunction

    function automatic bit m_misaligned(input int op, input logic [31:0] a);
        if (op == 2 || op == 3 || op == 6) return (a % 2) != 0;
        if (op == 4 || op == 7) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] mem);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        case (op)
            0: begin v = (mem >> (8 * off)) & 32'hFF; if (v >= 128) v = v + 32'hFFFFFF00; end
            1: v = (mem >> (8 * off)) & 32'hFF;
            2: begin v = (mem >> (16 * (off / 2))) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
            3: v = (mem >> (16 * (off / 2))) & 32'hFFFF;
            default: v = mem;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input int op, input logic [31:0] a);
        if (op == 5) return 4'(1 << (a % 4));
        if (op == 6) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] rt);
        if (op == 5) return (rt & 32'hFF) * 32'h01010101;
        if (op == 6) return (rt & 32'hFFFF) * 32'h00010001;
        return rt;
    endfunction

    // One full access: drive start, play the memory side, check everything.
    // waits < 0 means dm_ack is never given.
    task automatic run_access(input string name, input int op, input logic [31:0] a,
                              input logic [31:0] rt, input logic [31:0] mem,
                              input int waits, input bit spurious);
        bit          mis, st, tmo;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
        logic [1:0]  e_err;
        int          e_done, e_reqs, reqs, done_k, k;

        mis     = m_misaligned(op, a);
        st      = m_is_store(op);
        tmo     = !mis && (waits < 0 || waits >= TIMEOUT);
        e_addr  = a - (a % 4);
        e_be    = m_be(op, a);
        e_wdata = m_wdata(op, rt);
        e_rdata = (st || tmo) ? 32'd0 : m_load(op, a, mem);
        e_err   = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
        e_done  = mis ? 1 : (tmo ? TIMEOUT + 1 : waits + 2);
        e_reqs  = mis ? 0 : (tmo ? TIMEOUT : waits + 1);

        @(negedge clk);
        start    = 1'b1;
        mem_op   = 3'(op);
        addr     = a;
        wdata_in = rt;
        dm_ack   = 1'b0;
        reqs     = 0;
        done_k   = 0;
        k        = 0;
        while (done_k == 0 && k < LIMIT) begin
            @(negedge clk);
            k++;
            start    = 1'b0;
            mem_op   = 3'($urandom_range(0, 7));
            addr     = $urandom;
            wdata_in = $urandom;
            total++;
            if (busy !== 1'b1) begin
                bad++; $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
            end
            if (dm_req === 1'b1) begin
                reqs++;
                total++;
                if (dm_addr !== e_addr || dm_be !== e_be || dm_we !== st) begin
                    bad++;
                    $display("FAIL %s req%0d addr/be/we: got %h/%b/%b want %h/%b/%b",
                             name, reqs, dm_addr, dm_be, dm_we, e_addr, e_be, st);
                end
                if (st) begin
                    total++;
                    if (dm_wdata !== e_wdata) begin
                        bad++; $display("FAIL %s req%0d wdata: got %h want %h", name, reqs, dm_wdata, e_wdata);
                    end
                end
                if (spurious && reqs == 1) start = 1'b1;
                dm_ack   = (waits >= 0 && reqs == waits + 1);
                dm_rdata = dm_ack ? mem : $urandom;
            end else begin
                dm_ack   = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
            end
            if (done === 1'b1) begin
                done_k = k;
                total += 4;
                if (k != e_done) begin
                    bad++; $display("FAIL %s done cycle: got %0d want %0d", name, k, e_done);
                end
                if (reqs != e_reqs) begin
                    bad++; $display("FAIL %s req cycles: got %0d want %0d", name, reqs, e_reqs);
                end
                if (err !== e_err) begin
                    bad++; $display("FAIL %s err: got %b want %b", name, err, e_err);
                end
                if (!mis && rdata !== e_rdata) begin
                    bad++; $display("FAIL %s rdata: got %h want %h", name, rdata, e_rdata);
                end
            end
        end
        if (done_k == 0) begin
            total++; bad++;
            $display("FAIL %s no done within %0d cycles", name, LIMIT);
        end
        dm_ack = 1'b0;
        start  = 1'b0;
        // Idle afterwards: no second done, no request, results held.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || dm_req !== 1'b0 || busy !== 1'b0 || err !== e_err ||
                (!mis && rdata !== e_rdata)) begin
                bad++;
                $display("FAIL %s idle%0d: got done=%b req=%b busy=%b err=%b rdata=%h want 0/0/0/%b/%h",
                         name, j, done, dm_req, busy, err, rdata, e_err, e_rdata);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_op = '0; addr = '0; wdata_in = '0;
        dm_rdata = '0; dm_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, dm_req, dm_we} !== 4'b0 || rdata !== 32'd0 || err !== 2'b0 ||
            dm_addr !== 32'd0 || dm_be !== 4'd0 || dm_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b req=%b we=%b rdata=%h err=%b addr=%h be=%b wdata=%h want all 0",
                     busy, done, dm_req, dm_we, rdata, err, dm_addr, dm_be, dm_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_loads();
        run_access("lw",  4, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        run_access("lb",  0, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
        run_access("lbu", 1, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
        run_access("lh",  2, 32'h102, 32'h0, 32'h80112233, 0, 1'b0);
        run_access("lhu", 3, 32'h100, 32'h0, 32'h1122F344, 1, 1'b0);
    endtask

    task automatic test_store_wait();
        run_access("sb_wait", 5, 32'h205, 32'h000000AB, 32'h0, 3, 1'b0);
        run_access("sh_hi",   6, 32'h302, 32'h1234CDEF, 32'h0, 0, 1'b0);
        run_access("sw",      7, 32'h404, 32'hCAFEF00D, 32'h0, 2, 1'b0);
    endtask

    task automatic test_misaligned();
        run_access("lw_mis", 4, 32'h102, 32'h0, 32'h0, 0, 1'b0);
        run_access("sh_mis", 6, 32'h301, 32'h5555, 32'h0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_access("sw_timeout", 7, 32'h500, 32'h11223344, 32'h0, -1, 1'b0);
        run_access("ack_at_limit", 4, 32'h600, 32'h0, 32'h0BADF00D, TIMEOUT - 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; mem_op = 3'd7; addr = 32'h700; wdata_in = 32'h99; dm_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (dm_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid pre: got req=%b want 1", dm_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if (dm_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid async: got req=%b busy=%b done=%b want 0/0/0", dm_req, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            dm_ack = 1'($urandom_range(0, 1));
            total++;
            if (done !== 1'b0 || dm_req !== 1'b0 || err !== 2'b0 || rdata !== 32'd0) begin
                bad++;
                $display("FAIL rst_mid after%0d: got done=%b req=%b err=%b rdata=%h want 0", j, done, dm_req, err, rdata);
            end
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_access("busy_start_wait", 1, 32'h801, 32'h0, 32'h00C30000, 3, 1'b1);
        run_access("busy_start_fast", 7, 32'h900, 32'h76543210, 32'h0, 0, 1'b1);
    endtask

    task automatic test_random();
        int          op, waits;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 7);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 4 || op == 7) a = a - (a % 4);
                else if (op == 2 || op == 3 || op == 6) a = a - (a % 2);
            end
            waits = $urandom_range(0, 4);
            run_access("random", op, a, $urandom, $urandom, waits, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit that sits directly downstream of the EX-stage ALU. It takes the ALU result as the effective address and rt as store data. It performs one byte, halfword or word access to the data memory over a req/ack handshake with wait states, then returns the aligned, extended load value plus a done pulse to writeback. It reports misaligned accesses and memory timeouts instead of issuing them.

Parameters:
TIMEOUT, 16, REQ-state cycles without dm_ack before the access aborts with a timeout error; legal range 1..255.
ZERO_STORE_RDATA, 1, when 1, rdata is forced to 0 for store ops.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mem_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
addr  in  32  effective address (ALU result)
wdata_in  in  32  store data (rt)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  load result; valid while done=1
err  out  2  00 ok, 01 misaligned, 10 timeout; valid while done=1
dm_req  out  1  memory request, held until ack
dm_we  out  1  1 for SB/SH/SW
dm_addr  out  32  {addr[31:2],2'b00}
dm_be  out  4  byte enables, little-endian lanes
dm_wdata  out  32  lane-replicated store data
dm_rdata  in  32  memory read word
dm_ack  in  1  memory accepts or returns data this cycle

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high. All state clears the instant rst rises.
- Reset values: state=IDLE; busy, done, dm_req and dm_we = 0; rdata, err, dm_addr, dm_be, dm_wdata and the wait counter = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On start, latch mem_op, addr and wdata_in.
  - Misalignment check: LH, LHU or SH with addr[0]=1, or LW/SW with addr[1:0]!=0. On misalignment, go to RESP with err=01 and raise no dm_req.
  - Otherwise go to REQ.
- REQ:
  - dm_req=1; dm_addr, dm_be, dm_we and dm_wdata are driven from the latched values and stay stable until ack.
  - On dm_ack: for loads, capture the extracted lane into rdata; go to RESP with err=00.
  - Without ack, the counter increments. When the counter reaches TIMEOUT-1 and dm_ack=0, go to RESP with err=10 and rdata=0.
  - If dm_ack arrives in the same cycle as the timeout limit, ack wins.
- RESP: done=1 for exactly one cycle, then return to IDLE. The counter clears on entry to IDLE.
- Lane rules (little-endian; byte k = bits 8k+7:8k):
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rt[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
  - SW: be = 1111.
  - Loads drive be=1111.
  - LB and LH sign-extend the selected lane; LBU and LHU zero-extend; LW passes the word through.
- Latency: with ack in the first REQ cycle, start at cycle N gives dm_req at N+1 and done at N+2. Each wait state adds 1 cycle. A misaligned access gives done at N+1.
- start while busy: ignored, not queued.
- dm_ack outside REQ: ignored.
- dm_req is high only in REQ and drops the cycle after ack.
- rdata and err hold their values after done until the next access completes.
- Reset mid-access: dm_req drops asynchronously, the in-flight access is abandoned, and no done is produced.

Decomposition:
- Shared package mem_pkg:
  - mem_op encodings, e.g. MEMOP_LB..MEMOP_SW.
  - err codes ERR_OK, ERR_ALIGN, ERR_TIMEOUT.
  - FSM state encoding.
- Sub-module load_align: combinational function of (mem_op, addr[1:0], dm_rdata) producing rdata. It is reused by the single-cycle datapath's writeback path.
- Store lane and be generation stay inline.

Test Plan:
- LW, addr=0x100, memory returns 0xDEADBEEF with ack in the first REQ cycle -> dm_addr=0x100, be=1111, dm_we=0; done at start+2; rdata=0xDEADBEEF; err=00.
- LB, addr=0x103, dm_rdata=0x80112233 -> rdata=0xFFFFFF80. Repeat with LBU -> 0x00000080. LH at 0x102 -> 0xFFFF8011.
- SB, addr=0x205, rt=0x000000AB, ack after 3 wait cycles -> dm_addr=0x204, be=0010, dm_wdata=0xABABABAB, dm_we=1; address and data stable for all 4 REQ cycles; done at start+5.
- LW at 0x102 and SH at 0x301 -> no dm_req ever asserted; done at start+1; err=01.
- SW with dm_ack never asserted, TIMEOUT=16 -> dm_req high for exactly 16 cycles; done with err=10, rdata=0.
- Separately, ack on the 16th REQ cycle -> err=00.
- Assert rst during REQ -> dm_req low in the same cycle; no done.
- Separately, a start pulse issued while busy -> ignored; the original access still completes exactly once.
